// File: rtl/loop_counter_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | loop_counter_unit: loop/index counter behind a cmd/resp valid-ready port;  |
// | the decrement itself comes from the external decrement_module.            |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module loop_counter_unit #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_value,
  output logic             resp_zero,
  output logic             resp_underflow,
  output logic             count_zero,
  output logic [WIDTH-1:0] dec_in,
  input  logic [WIDTH-1:0] dec_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_DEC   = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             zero_q, zero_d;
  logic             uf_q, uf_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    count_d = count_q;
    value_d = value_q;
    zero_d  = zero_q;
    uf_d    = uf_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_LOAD:  count_d = data_q;
          OP_DEC:   count_d = dec_out;
          OP_READ:  count_d = count_q;
          OP_CLEAR: count_d = '0;
        endcase
        value_d = count_d;
        zero_d  = (count_d == '0);
        // Wrap is inferred from the pre-op count, not from dec_out.
        uf_d    = (op_q == OP_DEC) && (count_q == '0);
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      count_q <= '0;
      value_q <= '0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      count_q <= count_d;
      value_q <= value_d;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign resp_valid     = (state_q == S_RESP);
  assign resp_value     = value_q;
  assign resp_zero      = zero_q;
  assign resp_underflow = uf_q;
  assign count_zero     = (count_q == '0);
  assign dec_in         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_loop_counter_unit.sv
`default_nettype none
// Self-checking bench for loop_counter_unit; the decrementer is modelled inline.
module tb_loop_counter_unit;

  localparam int W = 20;
  localparam logic [1:0] LD = 2'b00, DC = 2'b01, RD = 2'b10, CL = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_value;
  logic         resp_zero;
  logic         resp_underflow;
  logic         count_zero;
  logic [W-1:0] dec_in;
  logic [W-1:0] dec_out;

  int n_pass = 0;
  int n_total = 0;

  loop_counter_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_value(resp_value),
    .resp_zero(resp_zero), .resp_underflow(resp_underflow), .count_zero(count_zero),
    .dec_in(dec_in), .dec_out(dec_out)
  );

  assign dec_out = dec_in - 1'b1;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Present one command, wait for its response, then hand it back.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] data,
                       output logic [W-1:0] v, output logic z, output logic u,
                       output logic cz, output int lat);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data  = $urandom;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    v  = resp_value;
    z  = resp_zero;
    u  = resp_underflow;
    cz = count_zero;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
    logic [W-1:0] exp_v;
    logic         exp_z;
    logic         exp_u;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] v;
    logic z, u, cz;
    int lat;
    int unsigned m;
    int unsigned seed_dummy;
    logic [1:0] rop;
    logic [W-1:0] rdata;
    logic exp_u;

    vecs[0] = '{LD, 20'h00003, 20'h00003, 1'b0, 1'b0};
    vecs[1] = '{DC, 20'h0AAAA, 20'h00002, 1'b0, 1'b0};
    vecs[2] = '{DC, 20'h00000, 20'h00001, 1'b0, 1'b0};
    vecs[3] = '{DC, 20'h00000, 20'h00000, 1'b1, 1'b0};
    vecs[4] = '{DC, 20'h00000, 20'hFFFFF, 1'b0, 1'b1};
    vecs[5] = '{RD, 20'h00007, 20'hFFFFF, 1'b0, 1'b0};
    vecs[6] = '{LD, 20'h00000, 20'h00000, 1'b1, 1'b0};
    vecs[7] = '{LD, 20'hFFFFF, 20'hFFFFF, 1'b0, 1'b0};
    vecs[8] = '{CL, 20'h12345, 20'h00000, 1'b1, 1'b0};
    vecs[9] = '{RD, 20'h00000, 20'h00000, 1'b1, 1'b0};

    #12;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_value", resp_value, 0);
    check("rst_resp_zero", resp_zero, 0);
    check("rst_resp_uf", resp_underflow, 0);
    check("rst_count_zero", count_zero, 1);
    check("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      check($sformatf("vec%0d_ready", i), cmd_ready, 1);
      issue(vecs[i].op, vecs[i].data, v, z, u, cz, lat);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_value", i), v, vecs[i].exp_v);
      check($sformatf("vec%0d_zero", i), z, vecs[i].exp_z);
      check($sformatf("vec%0d_uf", i), u, vecs[i].exp_u);
      check($sformatf("vec%0d_count_zero", i), cz, (vecs[i].exp_v == 0));
    end

    // Backpressure: response held, new command refused.
    issue(LD, 20'h00005, v, z, u, cz, lat);
    cmd_valid = 1'b1; cmd_op = DC; cmd_data = '0;
    @(posedge clk); #1;
    cmd_op = LD; cmd_data = 20'hABCDE;
    @(posedge clk); #1;
    check("bp_valid_start", resp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cmd_data = 20'hABCDE ^ W'(i);
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid", i), resp_valid, 1);
      check($sformatf("bp%0d_value", i), resp_value, 20'h00004);
      check($sformatf("bp%0d_cmd_ready", i), cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp_released", resp_valid, 0);
    issue(RD, 20'h0, v, z, u, cz, lat);
    check("bp_cmd_not_taken", v, 20'h00004);

    // Reset while a LOAD is executing.
    cmd_valid = 1'b1; cmd_op = LD; cmd_data = 20'h12345;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("midrst_in_exec", cmd_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_count", dec_in, 0);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("midrst_no_resp%0d", i), resp_valid, 0);
    end
    issue(RD, 20'h0, v, z, u, cz, lat);
    check("midrst_read", v, 0);

    // Randomized sequence against a plain arithmetic model.
    seed_dummy = $urandom(32'd20240611);
    m = 0;
    for (int i = 0; i < 200; i++) begin
      rop = 2'($urandom_range(0, 3));
      rdata = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 3));
      exp_u = 1'b0;
      if (rop == LD) m = rdata;
      else if (rop == DC) begin
        exp_u = (m == 0);
        m = (m + (1 << W) - 1) % (1 << W);
      end else if (rop == CL) m = 0;
      issue(rop, rdata, v, z, u, cz, lat);
      check($sformatf("rnd%0d_latency", i), lat, 2);
      check($sformatf("rnd%0d_value", i), v, m);
      check($sformatf("rnd%0d_zero", i), z, (m == 0));
      check($sformatf("rnd%0d_uf", i), u, exp_u);
      check($sformatf("rnd%0d_dec_in", i), dec_in, m);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
